// File: rtl/if_stage.sv
// Instruction fetch stage: PC ownership, single-outstanding imem reads and a
// 2-entry {instr, pc} buffer feeding decode, with redirect flush/drop handling.
module if_stage #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   ADDR_SIZE = 10,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 id_stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_pc,
    output logic                 instr_valid
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] req_pc;
    logic [WORD_SIZE-1:0] buf_instr [2];
    logic [WORD_SIZE-1:0] buf_pc    [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           count;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [2:0]           occ_next;
    logic [WORD_SIZE-1:0] redirect_target;

    assign redirect_target = redirect_pc & ~WORD_SIZE'(3);

    // Everything visible is gated by rst so outputs are quiet while reset is held.
    assign instr_valid = rst & (count != 2'd0);
    assign pop         = instr_valid & ~id_stall;
    assign push        = rst & (state == WAIT) & imem_rvalid & ~redirect;
    assign occ_next    = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    assign issue       = rst & ~redirect
                         & ((state == IDLE) | ((state == WAIT) & imem_rvalid))
                         & (occ_next <= 3'd1);

    assign imem_req  = issue;
    assign imem_addr = fetch_pc[ADDR_SIZE+1:2];
    assign instr     = instr_valid ? buf_instr[rd_ptr] : NOP_INSTR;
    assign instr_pc  = instr_valid ? buf_pc[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            state    <= IDLE;
        end else if (redirect) begin
            fetch_pc <= redirect_target;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            // A response still in flight must be swallowed when it lands.
            if (state != IDLE && !imem_rvalid)
                state <= DROP;
            else
                state <= IDLE;
        end else begin
            count <= occ_next[1:0];
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (issue) begin
                fetch_pc <= fetch_pc + WORD_SIZE'(4);
                state    <= WAIT;
            end else if (state != IDLE && imem_rvalid) begin
                state <= IDLE;
            end
        end
    end

    // With count = 2 a push only happens alongside a pop, so overwriting the
    // slot at wr_ptr (the departing head) is safe.
    always_ff @(posedge clk) begin
        if (issue)
            req_pc <= fetch_pc;
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage: owns the program counter, issues word reads to instruction memory, and supplies the decode stage with `instr` plus its PC through a 2-entry fetch buffer. It sits between instruction memory and `id_stage` and is the producer side of the instruction stream that `id_stage` consumes. The block absorbs decode stalls without losing in-flight responses, and honours branch/jump redirects by flushing and discarding stale fetches.

## Interface
- `WORD_SIZE`, 32, instruction and PC width
- `ADDR_SIZE`, 10, instruction memory word-address width
- `RESET_PC`, 0, byte address of the first fetch
- `NOP_INSTR`, 32'h00000013, ADDI x0,x0,0 driven when no instruction is valid

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-low
- `imem_req`  out  1  one-cycle read request
- `imem_addr`  out  ADDR_SIZE  word address, = `fetch_pc[ADDR_SIZE+1:2]`
- `imem_rvalid`  in  1  response strobe for the single outstanding request
- `imem_rdata`  in  WORD_SIZE  instruction word, valid with `imem_rvalid`
- `id_stall`  in  1  decode cannot accept this cycle
- `redirect`  in  1  branch/jump taken; one-cycle pulse
- `redirect_pc`  in  WORD_SIZE  new byte PC; bits [1:0] ignored (forced 0)
- `instr`  out  WORD_SIZE  buffer-head instruction, `NOP_INSTR` when empty
- `instr_pc`  out  WORD_SIZE  PC of `instr`, 0 when empty
- `instr_valid`  out  1  buffer non-empty

## Operation
- State: `fetch_pc` (next PC to request), `req_pc` (PC of outstanding request), 2-entry FIFO of {instr, pc}, `count` 0..2, FSM {IDLE, WAIT, DROP}.
- IDLE: no request outstanding. WAIT: one outstanding, response kept. DROP: one outstanding, response discarded.
- At most one request outstanding; `imem_rvalid` arrives ≥1 cycle after `imem_req`. An `imem_rvalid` in IDLE is ignored.
- pop = `instr_valid & ~id_stall`. push = WAIT & `imem_rvalid` & ~`redirect`.
- Issue condition (combinational `imem_req`): ~`redirect` & (IDLE | (WAIT & `imem_rvalid`)) & (count + push − pop ≤ 1). On issue: `req_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc` + 4, state → WAIT.
- `imem_addr` tracks `fetch_pc` combinationally; `fetch_pc` wraps modulo 2^WORD_SIZE, so `imem_addr` wraps modulo 2^ADDR_SIZE.
- WAIT & `imem_rvalid` without a new issue → IDLE. DROP & `imem_rvalid` → IDLE, data discarded, no push.
- Redirect (highest priority): FIFO flushed (count ← 0, no push, pop ignored), `fetch_pc` ← {`redirect_pc`[31:2], 2'b00}, no issue that cycle. State: WAIT without `rvalid` → DROP; WAIT with `rvalid` → IDLE; DROP without `rvalid` stays DROP; DROP with `rvalid` → IDLE; IDLE stays IDLE.
- Simultaneous push and pop with count = 2 is legal: head leaves, new entry enters, count stays 2. Push with count = 2 and no pop cannot occur because the issue condition forbids it.

## Timing
- Reset (`rst` = 0 at edge): `fetch_pc` = RESET_PC, count = 0, state IDLE. Combinational outputs during reset: `imem_req` = 0, `instr_valid` = 0, `instr` = NOP_INSTR, `instr_pc` = 0. Reset mid-transaction abandons the outstanding request; a late `rvalid` arrives in IDLE and is ignored.
- First `imem_req` occurs in the first cycle with `rst` = 1.
- With 1-cycle memory latency and no stall: req at cycle N, `rvalid` at N+1, `instr_valid` at N+2. Sustained throughput is one instruction per cycle from N+1 onward.
- Redirect at cycle R: first request to the new PC at R+1 if IDLE; otherwise one cycle after the dropped response. The new instruction is visible no earlier than R+3.
- `instr`/`instr_pc` stay stable while `instr_valid` & `id_stall`.

## Test plan
- Reset release, 1-cycle memory returning `addr*4`: `imem_addr` = 0,1,2,…; `instr_pc` = 0,4,8,… one per cycle from cycle 2; `instr` = NOP_INSTR before.
- Hold `id_stall` = 1 for 5 cycles mid-stream: `count` saturates at 2, `imem_req` stays low, and on release PCs continue with no gap or duplicate.
- 3-cycle memory latency: one req every 3 cycles, never two outstanding; output PC sequence is contiguous.
- `redirect` with `redirect_pc` = 0x100 while WAIT (latency 3): buffer empties next cycle, stale response dropped, next `imem_addr` = 0x40, first valid `instr_pc` = 0x100.
- `redirect` coincident with `imem_rvalid` and `id_stall` = 1, `count` = 2: no push, buffer flushed, state IDLE, fetch restarts at `redirect_pc`; `redirect_pc` = 0x103 fetches 0x100.
- Assert `rst` = 0 while WAIT, then deliver `rvalid` during and after reset: the response is ignored, and the first post-reset output is `instr_pc` = RESET_PC.
